// File: rtl/wb_bus_if_pkg.sv
// Shared types and constants for the Wishbone bus interface bridge.
// Encodings are fixed so waveforms decode the same across instances.
package wb_bus_if_pkg;

  typedef enum logic [1:0] {
    WB_IDLE       = 2'd0,
    WB_BUSY       = 2'd1,
    WB_WAIT_STALL = 2'd2
  } wb_state_e;

  localparam int          WB_TIMEOUT_DEF = 64;
  localparam int          REG_BUS_W      = 32;
  localparam logic [31:0] ZERO_WORD      = 32'h0;

endpackage

// File: rtl/wb_bus_if.sv
// Bridges one single-cycle CPU memory port to a Wishbone B3 classic master.
// Holds the pipeline until ack/timeout; buffers read data across ctrl stalls.
module wb_bus_if
  import wb_bus_if_pkg::*;
#(
  parameter int TIMEOUT = WB_TIMEOUT_DEF,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  output logic [31:0] cpu_data_o,
  output logic        stall_req_o,
  output logic        bus_err_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o
);

  wb_state_e         state;
  wb_state_e         state_n;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       rd_buf;
  logic              start;
  logic              done;
  logic              abort;
  logic              timeout_hit;

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_n     = state;
    stall_req_o = 1'b0;
    cpu_data_o  = ZERO_WORD;
    start       = 1'b0;
    done        = 1'b0;
    abort       = 1'b0;
    unique case (state)
      WB_IDLE: begin
        stall_req_o = cpu_ce_i;
        if (cpu_ce_i && (stall_i == 6'd0)) begin
          start   = 1'b1;
          state_n = WB_BUSY;
        end
      end
      WB_BUSY: begin
        stall_req_o = 1'b1;
        // ack beats a simultaneous timeout
        if (wb_ack_i) begin
          done        = 1'b1;
          stall_req_o = 1'b0;
          if (!wb_we_o)
            cpu_data_o = wb_data_i;
        end else if (timeout_hit) begin
          abort       = 1'b1;
          stall_req_o = 1'b0;
        end
        if (done || abort)
          state_n = (stall_i != 6'd0) ? WB_WAIT_STALL : WB_IDLE;
      end
      WB_WAIT_STALL: begin
        cpu_data_o = rd_buf;
        if (stall_i == 6'd0)
          state_n = WB_IDLE;
      end
      default: state_n = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WB_IDLE;
      cnt       <= '0;
      rd_buf    <= ZERO_WORD;
      bus_err_o <= 1'b0;
      wb_addr_o <= ZERO_WORD;
      wb_data_o <= ZERO_WORD;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= 4'h0;
      wb_stb_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
    end else begin
      state     <= state_n;
      bus_err_o <= abort;
      if (start) begin
        wb_addr_o <= cpu_addr_i;
        wb_data_o <= cpu_data_i;
        wb_we_o   <= cpu_we_i;
        wb_sel_o  <= cpu_sel_i;
        wb_stb_o  <= 1'b1;
        wb_cyc_o  <= 1'b1;
        cnt       <= '0;
      end else if (state == WB_BUSY) begin
        cnt <= cnt + CNT_W'(1);
        if (done) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          wb_we_o  <= 1'b0;
          wb_sel_o <= 4'h0;
          rd_buf   <= wb_data_i;
        end else if (abort) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          rd_buf   <= ZERO_WORD;
        end
      end
    end
  end

endmodule
